// File: rtl/tinyalu_pkg.sv
// Shared types and widths for the tinyalu subsystem.
package tinyalu_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned RESULT_W  = 9;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/tinyalu_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant_c,
    output logic [$clog2(N_REQ)-1:0] idx_c,
    output logic                     found_c
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    always_comb begin
        int unsigned j;
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr) + i) % N_REQ;
            if (!found_c && req[j]) begin
                found_c    = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one single-cycle TinyALU among N_REQ requesters, round-robin, with a done watchdog.
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*8-1:0]     req_a,
    input  logic [N_REQ*8-1:0]     req_b,
    input  logic [N_REQ*3-1:0]     req_op,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [8:0]             rsp_result,
    output logic                   rsp_err,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [8:0]             alu_result
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e           state, state_n;
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [OPERAND_W-1:0] a_q, a_n, b_q, b_n;
    logic [OP_W-1:0]      op_q, op_n;
    logic [CNT_W-1:0]     cnt, cnt_n;

    logic [N_REQ-1:0]     req_ready_n, rsp_valid_n;
    logic [RESULT_W-1:0]  rsp_result_n;
    logic                 rsp_err_n;
    logic [OPERAND_W-1:0] alu_a_n, alu_b_n;
    logic [OP_W-1:0]      alu_op_n;
    logic                 alu_start_n;

    logic [N_REQ-1:0]     grant_c;
    logic [IDX_W-1:0]     idx_c;
    logic                 found_c;
    logic [OP_W-1:0]      op_sel_c;
    logic [N_REQ-1:0]     rsp_onehot_c;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .found_c (found_c)
    );

    assign op_sel_c     = req_op[idx_c*OP_W +: OP_W];
    assign rsp_onehot_c = N_REQ'(1) << idx_q;

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        idx_n        = idx_q;
        a_n          = a_q;
        b_n          = b_q;
        op_n         = op_q;
        cnt_n        = cnt;
        req_ready_n  = '0;
        rsp_valid_n  = '0;
        rsp_result_n = '0;
        rsp_err_n    = 1'b0;
        alu_start_n  = 1'b0;
        alu_a_n      = alu_a;
        alu_b_n      = alu_b;
        alu_op_n     = alu_op;

        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    req_ready_n = grant_c;
                    idx_n       = idx_c;
                    a_n         = req_a[idx_c*OPERAND_W +: OPERAND_W];
                    b_n         = req_b[idx_c*OPERAND_W +: OPERAND_W];
                    op_n        = op_sel_c;
                    ptr_n       = (idx_c == IDX_W'(N_REQ - 1)) ? '0 : idx_c + IDX_W'(1);
                    state_n     = (op_sel_c == OP_NOP) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start_n = 1'b1;
                alu_a_n     = a_q;
                alu_b_n     = b_q;
                alu_op_n    = op_q;
                cnt_n       = '0;
                state_n     = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    rsp_valid_n  = rsp_onehot_c;
                    rsp_result_n = alu_result;
                    state_n      = ST_RESP;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    rsp_valid_n = rsp_onehot_c;
                    rsp_err_n   = 1'b1;
                    state_n     = ST_RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Arriving from WAIT the response is already on the outputs; a NOP arrives
                // straight from IDLE and presents its error response one cycle later.
                if (rsp_valid == '0) begin
                    rsp_valid_n = rsp_onehot_c;
                    rsp_err_n   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            idx_q      <= idx_n;
            a_q        <= a_n;
            b_q        <= b_n;
            op_q       <= op_n;
            cnt        <= cnt_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_result <= rsp_result_n;
            rsp_err    <= rsp_err_n;
            alu_a      <= alu_a_n;
            alu_b      <= alu_b_n;
            alu_op     <= alu_op_n;
            alu_start  <= alu_start_n;
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: directed scenarios plus randomized round-robin traffic.
module tb_tinyalu_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_a, req_b;
    logic [N*3-1:0] req_op;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [8:0]     rsp_result;
    logic           rsp_err;
    logic [7:0]     alu_a, alu_b;
    logic [2:0]     alu_op;
    logic           alu_start;
    logic           alu_done = 1'b0;
    logic [8:0]     alu_result = '0;

    logic [7:0] ra [N];
    logic [7:0] rb [N];
    logic [2:0] rop [N];
    logic       alu_hang = 1'b0;
    logic       spur_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    tinyalu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_op = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8]  = ra[i];
            req_b[i*8 +: 8]  = rb[i];
            req_op[i*3 +: 3] = rop[i];
        end
    end

    function automatic logic [8:0] exp_result(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd1:    return 9'(a) + 9'(b);
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Single-cycle ALU: done one cycle after start; junk result on spurious pulses.
    always @(posedge clk) begin
        alu_done   <= (alu_start && !alu_hang) || spur_done;
        alu_result <= alu_start ? exp_result(alu_a, alu_b, alu_op) : 9'h1AA;
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got rdy=%b vld=%b res=%h err=%b want all 0",
                     req_ready, rsp_valid, rsp_result, rsp_err);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h start=%b want all 0",
                     alu_a, alu_b, alu_op, alu_start);
        end
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single();
        int t;
        bit got;
        @(negedge clk);
        ra[1] = 8'hFF; rb[1] = 8'h01; rop[1] = 3'b001; req_valid = 4'b0010;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: got %b want 0010", req_ready);
        end
        req_valid = '0;
        model_ptr = 2;
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b1 || alu_a !== 8'hFF || alu_b !== 8'h01 || alu_op !== 3'b001) begin
            errors++;
            $display("FAIL single_issue: got start=%b a=%h b=%h op=%h want 1 ff 01 1",
                     alu_start, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || rsp_result !== '0) begin
            errors++;
            $display("FAIL single_early_rsp: got vld=%b res=%h want 0 0", rsp_valid, rsp_result);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_result !== 9'h100 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got vld=%b res=%h err=%b want 0010 100 0",
                     rsp_valid, rsp_result, rsp_err);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || rsp_result !== '0) begin
            errors++;
            $display("FAIL single_rsp_clear: got vld=%b res=%h want 0 0", rsp_valid, rsp_result);
        end
    endtask

    task automatic test_nop();
        int t;
        bit got;
        bit started;
        @(negedge clk);
        ra[2] = 8'h12; rb[2] = 8'h34; rop[2] = 3'b000; req_valid = 4'b0100;
        got = 0;
        started = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL nop_grant: got %b want 0100", req_ready);
        end
        req_valid = '0;
        model_ptr = 3;
        started = started | alu_start;
        @(negedge clk);
        started = started | alu_start;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_result !== '0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL nop_rsp: got vld=%b res=%h err=%b want 0100 0 1",
                     rsp_valid, rsp_result, rsp_err);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            started = started | alu_start;
        end
        checks++;
        if (started !== 1'b0) begin
            errors++;
            $display("FAIL nop_no_start: got alu_start seen=%b want 0", started);
        end
    endtask

    task automatic test_round_robin(input int n_txn, input bit random_subset);
        int t, exp_idx, pick;
        bit got;
        logic [7:0] a, b;
        logic [2:0] op;
        logic [N-1:0] oh;
        for (int n = 0; n < n_txn; n++) begin
            if (random_subset) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                        ra[i] = 8'($urandom); rb[i] = 8'($urandom); rop[i] = 3'($urandom);
                        req_valid[i] = 1'b1;
                    end
                end
                if (req_valid == '0) begin
                    pick = int'($urandom_range(N - 1, 0));
                    ra[pick] = 8'($urandom); rb[pick] = 8'($urandom); rop[pick] = 3'($urandom);
                    req_valid[pick] = 1'b1;
                end
            end
            got = 0;
            for (t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rr_grant_timeout: got no req_ready want a grant (txn %0d)", n);
                return;
            end
            exp_idx = rr_pick(req_valid, model_ptr);
            oh = '0;
            oh[exp_idx] = 1'b1;
            checks++;
            if (req_ready !== oh) begin
                errors++;
                $display("FAIL rr_grant: got %b want %b (txn %0d)", req_ready, oh, n);
            end
            a = ra[exp_idx]; b = rb[exp_idx]; op = rop[exp_idx];
            model_ptr = (exp_idx + 1) % N;
            if (random_subset) begin
                req_valid[exp_idx] = 1'b0;
            end else begin
                ra[exp_idx] = 8'($urandom); rb[exp_idx] = 8'($urandom);
            end
            @(negedge clk);
            if (op == 3'b000) begin
                checks++;
                if (rsp_valid !== oh || rsp_result !== '0 || rsp_err !== 1'b1 || alu_start !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_nop_rsp: got vld=%b res=%h err=%b start=%b want %b 0 1 0",
                             rsp_valid, rsp_result, rsp_err, alu_start, oh);
                end
            end else begin
                checks++;
                if (alu_start !== 1'b1 || alu_a !== a || alu_b !== b || alu_op !== op) begin
                    errors++;
                    $display("FAIL rr_issue: got start=%b a=%h b=%h op=%h want 1 %h %h %h",
                             alu_start, alu_a, alu_b, alu_op, a, b, op);
                end
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (rsp_valid !== oh || rsp_result !== exp_result(a, b, op) || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rsp: got vld=%b res=%h err=%b want %b %h 0",
                             rsp_valid, rsp_result, rsp_err, oh, exp_result(a, b, op));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t, k;
        bit got;
        @(negedge clk);
        req_valid = '0;
        alu_hang = 1'b1;
        ra[3] = 8'h5A; rb[3] = 8'hC3; rop[3] = 3'b011; req_valid[3] = 1'b1;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_grant: got %b want 1000", req_ready);
        end
        req_valid = '0;
        model_ptr = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (alu_op !== 3'b011 || alu_a !== 8'h5A || alu_start !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_hold: got op=%h a=%h start=%b want 3 5a 0",
                             alu_op, alu_a, alu_start);
                end
            end
            if (rsp_valid != '0) break;
        end
        checks++;
        if (k != TO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", k, TO + 2);
        end
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_result !== '0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: got vld=%b res=%h err=%b want 1000 0 1",
                     rsp_valid, rsp_result, rsp_err);
        end
        alu_hang = 1'b0;
    endtask

    task automatic test_spurious();
        int t;
        bit got, bad;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid != '0 || req_ready != '0 || alu_start != 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL spurious_idle: got activity=%b want 0", bad);
        end
        ra[model_ptr] = 8'h81; rb[model_ptr] = 8'h7F; rop[model_ptr] = 3'b001;
        req_valid[model_ptr] = 1'b1;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        checks++;
        if (rsp_valid == '0 || rsp_result !== 9'h100 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL spurious_txn_rsp: got vld=%b res=%h err=%b want nonzero 100 0",
                     rsp_valid, rsp_result, rsp_err);
        end
        model_ptr = (model_ptr + 1) % N;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid != '0 || alu_start != 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL spurious_resp: got extra activity=%b want 0", bad);
        end
    endtask

    task automatic test_reset_mid_wait();
        int t;
        bit got, bad;
        @(negedge clk);
        req_valid = '0;
        ra[1] = 8'h05; rb[1] = 8'h07; rop[1] = 3'b001; req_valid[1] = 1'b1;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_start: got %b want 1", alu_start);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start} !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs: got vld=%b a=%h op=%h start=%b want all 0",
                     rsp_valid, alu_a, alu_op, alu_start);
        end
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstwait_dropped: got rsp_valid after reset=%b want 0", bad);
        end
        ra[0] = 8'h0F; rb[0] = 8'h3C; rop[0] = 3'b010; req_valid[0] = 1'b1;
        ra[2] = 8'h11; rb[2] = 8'h22; rop[2] = 3'b011; req_valid[2] = 1'b1;
        got = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstwait_ptr: got %b want 0001", req_ready);
        end
        req_valid[0] = 1'b0;
        model_ptr = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 9'h00C || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_rsp: got vld=%b res=%h err=%b want 0001 00c 0",
                     rsp_valid, rsp_result, rsp_err);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        #2 reset = 1'b1;
        test_reset();
        test_single();
        test_nop();
        test_reset();
        ra[0] = 8'hF0; rb[0] = 8'h3C; rop[0] = 3'b010;
        ra[1] = 8'hAA; rb[1] = 8'h0F; rop[1] = 3'b011;
        ra[2] = 8'hC8; rb[2] = 8'h64; rop[2] = 3'b001;
        ra[3] = 8'h77; rb[3] = 8'h1E; rop[3] = 3'b010;
        @(negedge clk);
        req_valid = '1;
        test_round_robin(5, 1'b0);
        req_valid = '0;
        test_timeout();
        test_round_robin(30, 1'b1);
        test_spurious();
        test_reset_mid_wait();
        test_round_robin(20, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
